// File: rtl/itof_pkg.sv
// Shared constants and rounding helper for the integer-to-binary32 converter.
package itof_pkg;

    localparam int FP32_BIAS  = 127;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rm_e;

    // Decides whether the truncated mantissa must be bumped by one ulp.
    function automatic logic round_inc(input rm_e rm, input logic sign, input logic lsb,
                                       input logic guard, input logic sticky);
        logic inc;
        inc = 1'b0;
        case (rm)
            RM_RNE: inc = guard & (sticky | lsb);
            RM_RTZ: inc = 1'b0;
            RM_RDN: inc = sign & (guard | sticky);
            RM_RUP: inc = ~sign & (guard | sticky);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/itof_lzc.sv
// Leading-one detector: reports the index of the most significant set bit.
module itof_lzc #(
    parameter  int WIDTH = 32,
    localparam int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [PW-1:0]    pos,
    output logic             zero
);

    // Later (higher) set bits override earlier ones, leaving the topmost index.
    always_comb begin
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                pos = PW'(i);
            end
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 binary32 converter with a single global stall.
module itof_pipe
    import itof_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_x,
    input  logic [1:0]      in_rm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_y,
    output logic            out_inexact
);

    localparam int PW = $clog2(IN_W);
    localparam int SW = PW + 1;
    localparam int EW = IN_W + 24;
    localparam int MW = FP32_MAN_W;
    localparam int XW = FP32_EXP_W;

    logic en;

    logic            s1_valid;
    logic            s1_sign;
    logic [IN_W-1:0] s1_mag;
    rm_e             s1_rm;

    logic            s2_valid;
    logic            s2_sign;
    logic [XW-1:0]   s2_exp;
    logic [IN_W-1:0] s2_frac;
    rm_e             s2_rm;

    logic            x_neg;
    logic [IN_W-1:0] x_mag;

    logic [PW-1:0]   lz_pos;
    logic            lz_zero;
    logic [SW-1:0]   norm_sh;
    logic [IN_W-1:0] norm_frac;
    logic [XW-1:0]   norm_exp;

    logic [EW-1:0]   ext;
    logic [MW-1:0]   mant;
    logic            guard;
    logic            sticky;
    logic            inc;
    logic [MW:0]     mant_sum;
    logic [XW-1:0]   exp_r;
    logic [31:0]     y_next;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1: split into sign and magnitude; negation wraps so the most negative value stays correct.
    assign x_neg = SIGNED_IN && in_x[IN_W-1];
    assign x_mag = x_neg ? -in_x : in_x;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_rm    <= RM_RNE;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= x_neg;
            s1_mag   <= x_mag;
            s1_rm    <= rm_e'(in_rm);
        end
    end

    // S2: shift one past the leading one so only the fraction bits remain, MSB-aligned.
    itof_lzc #(
        .WIDTH(IN_W)
    ) u_lzc (
        .data(s1_mag),
        .pos (lz_pos),
        .zero(lz_zero)
    );

    assign norm_sh   = SW'(IN_W) - {1'b0, lz_pos};
    assign norm_frac = s1_mag << norm_sh;
    assign norm_exp  = lz_zero ? '0 : (XW'(FP32_BIAS) + {{(XW-PW){1'b0}}, lz_pos});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_frac  <= '0;
            s2_rm    <= RM_RNE;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_exp   <= norm_exp;
            s2_frac  <= norm_frac;
            s2_rm    <= s1_rm;
        end
    end

    // S3: zero padding below the fraction covers narrow inputs where everything is exact.
    assign ext      = {s2_frac, 24'b0};
    assign mant     = ext[EW-1 -: MW];
    assign guard    = ext[EW-1-MW];
    assign sticky   = |ext[EW-2-MW:0];
    assign inc      = round_inc(s2_rm, s2_sign, mant[0], guard, sticky);
    assign mant_sum = {1'b0, mant} + {{MW{1'b0}}, inc};
    assign exp_r    = s2_exp + {{(XW-1){1'b0}}, mant_sum[MW]};
    assign y_next   = {s2_sign, exp_r, mant_sum[MW-1:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            out_y       <= '0;
            out_inexact <= 1'b0;
        end else if (en) begin
            out_valid   <= s2_valid;
            out_y       <= y_next;
            out_inexact <= guard | sticky;
        end
    end

endmodule
